diff_cost_seq: RTL and testbench

//  Sequential, handshaked cost-derivative unit for the output layer of backprop.

---
 rtl/diff_cost_seq_pkg.sv | 14 +
 rtl/diff_cost_seq_if.sv | 14 +
 rtl/diff_cost_lane.sv | 27 ++
 rtl/diff_cost_seq.sv | 74 +++++++
 tb/tb_diff_cost_seq.sv | 133 +++++++++++++
 5 files changed

// File: rtl/diff_cost_seq_pkg.sv
// diff_cost_seq_pkg: shared gradient mode/state types, clamp and reciprocal helpers
package diff_cost_seq_pkg;
   typedef enum logic [1:0] {GDO_MSE, GDO_DIFF, GDO_MEAN, GDO_RSVD} gdo_mode_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} gdo_state_e;
   function automatic longint gdo_inv(input int size, input int frac);
      return ((longint'(1) <<< frac) + longint'(size / 2)) / longint'(size);
   endfunction
   function automatic logic signed [63:0] gdo_sat(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return x > hi ? hi : (x < lo ? lo : x);
   endfunction
endpackage

// File: rtl/diff_cost_seq_if.sv
// diff_cost_seq_if: request/result handshake bundle for the cost-derivative unit
interface diff_cost_seq_if #(parameter int SIZE = 3, parameter int DATA_SIZE = 16);
   logic                      in_valid;
   logic                      in_ready;
   logic [1:0]                in_mode;
   logic [SIZE*DATA_SIZE-1:0] predict;
   logic [SIZE*DATA_SIZE-1:0] z;
   logic                      out_valid;
   logic                      out_ready;
   logic [SIZE*DATA_SIZE-1:0] diff;
   logic                      sat;
   modport slave (input in_valid, in_mode, predict, z, out_ready, output in_ready, out_valid, diff, sat);
   modport master (output in_valid, in_mode, predict, z, out_ready, input in_ready, out_valid, diff, sat);
endinterface

// File: rtl/diff_cost_lane.sv
// diff_cost_lane: one-element cost derivative (subtract, scale, saturate)
module diff_cost_lane
   import diff_cost_seq_pkg::*;
#(
   parameter int DATA_SIZE = 16,
   parameter int FRAC      = DATA_SIZE / 2,
   parameter int SIZE      = 3
) (
   input  logic [DATA_SIZE-1:0] i_p,
   input  logic [DATA_SIZE-1:0] i_z,
   input  gdo_mode_e            i_mode,
   output logic [DATA_SIZE-1:0] o_d,
   output logic                 o_sat
);
   localparam longint INV_SIZE = gdo_inv(SIZE, FRAC);
   logic signed [DATA_SIZE:0]   w_d;
   logic signed [DATA_SIZE+1:0] w_d2;
   logic signed [63:0]          w_pre, w_cl;
   assign w_d   = {i_p[DATA_SIZE-1], i_p} - {i_z[DATA_SIZE-1], i_z};
   assign w_d2  = {w_d, 1'b0};
   // mean path floors via arithmetic shift of the Q-format product
   assign w_pre = i_mode == GDO_MEAN ? (64'(w_d2) * INV_SIZE) >>> FRAC
                : i_mode == GDO_MSE  ? 64'(w_d2) : 64'(w_d);
   assign w_cl  = gdo_sat(w_pre, DATA_SIZE);
   assign o_d   = w_cl[DATA_SIZE-1:0];
   assign o_sat = w_cl != w_pre;
endmodule

// File: rtl/diff_cost_seq.sv
// diff_cost_seq: handshaked sequential dC/da unit, LANES elements per RUN cycle
module diff_cost_seq
   import diff_cost_seq_pkg::*;
#(
   parameter int SIZE      = 3,
   parameter int DATA_SIZE = 16,
   parameter int FRAC      = DATA_SIZE / 2,
   parameter int LANES     = 1
) (
   input logic             clk,
   input logic             rst_n,
   diff_cost_seq_if.slave  bus
);
   localparam int STEPS = SIZE / LANES;
   localparam int IW    = STEPS > 1 ? $clog2(STEPS) : 1;
   localparam int VW    = SIZE * DATA_SIZE;
   if (SIZE % LANES != 0) begin : g_bad_lanes
      $error("SIZE must be a multiple of LANES");
   end
   gdo_state_e           r_state, w_next;
   gdo_mode_e            r_mode;
   logic [IW-1:0]        r_idx;
   logic [VW-1:0]        r_p, r_z, r_diff;
   logic                 r_sat, w_last;
   int                   w_base;
   logic [DATA_SIZE-1:0] w_p [LANES];
   logic [DATA_SIZE-1:0] w_z [LANES];
   logic [DATA_SIZE-1:0] w_d [LANES];
   logic [LANES-1:0]     w_s;
   assign w_last        = r_idx == IW'(STEPS - 1);
   assign w_base        = int'(r_idx) * LANES;
   assign bus.in_ready  = r_state == S_IDLE;
   assign bus.out_valid = r_state == S_DONE;
   assign bus.diff      = r_diff;
   assign bus.sat       = r_sat;
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_p[l] = r_p[(w_base + l) * DATA_SIZE +: DATA_SIZE];
      assign w_z[l] = r_z[(w_base + l) * DATA_SIZE +: DATA_SIZE];
      diff_cost_lane #(.DATA_SIZE(DATA_SIZE), .FRAC(FRAC), .SIZE(SIZE)) u_lane (
         .i_p(w_p[l]), .i_z(w_z[l]), .i_mode(r_mode), .o_d(w_d[l]), .o_sat(w_s[l])
      );
   end
   always_comb begin
      w_next = r_state;
      w_next = r_state == S_IDLE ? (bus.in_valid ? S_RUN : S_IDLE)
             : r_state == S_RUN  ? (w_last ? S_DONE : S_RUN)
             : (bus.out_ready ? S_IDLE : S_DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_mode  <= GDO_MSE;
         r_idx   <= '0;
         r_p     <= '0;
         r_z     <= '0;
         r_diff  <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && bus.in_valid) begin
            r_p    <= bus.predict;
            r_z    <= bus.z;
            r_mode <= gdo_mode_e'(bus.in_mode);
            r_idx  <= '0;
            r_sat  <= 1'b0;
         end
         if (r_state == S_RUN) begin
            for (int i = 0; i < LANES; i++) r_diff[(w_base + i) * DATA_SIZE +: DATA_SIZE] <= w_d[i];
            r_sat <= r_sat | (|w_s);
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_diff_cost_seq.sv
// tb_diff_cost_seq: directed vectors against LANES=1 and LANES=3 instances side by side
module tb_diff_cost_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   spur;
   always #5 clk = ~clk;
   diff_cost_seq_if #(.SIZE(3), .DATA_SIZE(16)) b1 ();
   diff_cost_seq_if #(.SIZE(3), .DATA_SIZE(16)) b3 ();
   diff_cost_seq #(.SIZE(3), .DATA_SIZE(16), .FRAC(8), .LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   diff_cost_seq #(.SIZE(3), .DATA_SIZE(16), .FRAC(8), .LANES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [47:0] v3(input logic [15:0] e2, input logic [15:0] e1, input logic [15:0] e0);
      return {e2, e1, e0};
   endfunction
   task automatic drive(input logic v, input logic [1:0] m, input logic [47:0] p, input logic [47:0] z);
      b1.in_valid = v; b1.in_mode = m; b1.predict = p; b1.z = z;
      b3.in_valid = v; b3.in_mode = m; b3.predict = p; b3.z = z;
   endtask
   task automatic xact(input string tag, input logic [1:0] m, input logic [47:0] p, input logic [47:0] z,
                       input logic [47:0] exp, input logic es);
      int lat1 = -1, lat3 = -1;
      logic [47:0] d1 = 'x, d3 = 'x;
      logic s1 = 1'bx, s3 = 1'bx;
      @(negedge clk);
      drive(1'b1, m, p, z);
      check({tag, "_rdy1"}, 64'(b1.in_ready), 64'd1);
      check({tag, "_rdy3"}, 64'(b3.in_ready), 64'd1);
      @(posedge clk); #1;
      drive(1'b0, ~m, ~p, ~z);
      for (int c = 1; c <= 20 && (lat1 < 0 || lat3 < 0); c++) begin
         if (b1.out_valid && lat1 < 0) begin lat1 = c; d1 = b1.diff; s1 = b1.sat; end
         if (b3.out_valid && lat3 < 0) begin lat3 = c; d3 = b3.diff; s3 = b3.sat; end
         @(posedge clk); #1;
      end
      check({tag, "_lat1"}, 64'(lat1), 64'd4);
      check({tag, "_lat3"}, 64'(lat3), 64'd2);
      check({tag, "_diff1"}, 64'(d1), 64'(exp));
      check({tag, "_diff3"}, 64'(d3), 64'(exp));
      check({tag, "_sat1"}, 64'(s1), 64'(es));
      check({tag, "_sat3"}, 64'(s3), 64'(es));
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      b1.out_ready = 1'b1;
      b3.out_ready = 1'b1;
      drive(1'b0, 2'b00, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy1", 64'(b1.in_ready), 64'd1);
      check("rst_ov1", 64'(b1.out_valid), 64'd0);
      check("rst_diff1", 64'(b1.diff), 64'd0);
      check("rst_sat1", 64'(b1.sat), 64'd0);
      check("rst_rdy3", 64'(b3.in_ready), 64'd1);
      check("rst_ov3", 64'(b3.out_valid), 64'd0);
      check("rst_diff3", 64'(b3.diff), 64'd0);
      check("rst_sat3", 64'(b3.sat), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      xact("mse", 2'b00, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0100, 16'h0100, 16'h0100), 1'b0);
      xact("dif", 2'b01, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0080, 16'h0080, 16'h0080), 1'b0);
      xact("rsv", 2'b11, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0080, 16'h0080, 16'h0080), 1'b0);
      xact("neg", 2'b01, v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0180, 16'h0180, 16'h0180), v3(16'hFF80, 16'hFF80, 16'hFF80), 1'b0);
      xact("mean", 2'b10, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0055, 16'h0055, 16'h0055), 1'b0);
      xact("mneg", 2'b10, v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0180, 16'h0180, 16'h0180), v3(16'hFFAB, 16'hFFAB, 16'hFFAB), 1'b0);
      xact("mflr", 2'b10, v3(16'h0180, 16'h00FF, 16'h0101), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0055, 16'hFFFF, 16'h0000), 1'b0);
      xact("msat", 2'b10, v3(16'h7FFF, 16'h7FFF, 16'h7FFF), v3(16'h8000, 16'h8000, 16'h8000), v3(16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1);
      xact("satp", 2'b00, v3(16'h7F00, 16'h7F00, 16'h7F00), v3(16'h8000, 16'h8000, 16'h8000), v3(16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1);
      xact("satn", 2'b00, v3(16'h8000, 16'h8000, 16'h8000), v3(16'h7F00, 16'h7F00, 16'h7F00), v3(16'h8000, 16'h8000, 16'h8000), 1'b1);
      xact("clean", 2'b00, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0100, 16'h0100, 16'h0100), 1'b0);
      xact("sat1e", 2'b00, v3(16'h0180, 16'h7F00, 16'h0180), v3(16'h0100, 16'h8000, 16'h0100), v3(16'h0100, 16'h7FFF, 16'h0100), 1'b1);
      xact("dsat", 2'b01, v3(16'h7FFF, 16'h0000, 16'h8000), v3(16'h8000, 16'h0000, 16'h0001), v3(16'h7FFF, 16'h0000, 16'h8000), 1'b1);
      xact("edge", 2'b01, v3(16'h7FFF, 16'h8000, 16'h0000), v3(16'h0000, 16'h0000, 16'h0000), v3(16'h7FFF, 16'h8000, 16'h0000), 1'b0);
      @(negedge clk);
      b1.out_ready = 1'b0;
      b3.out_ready = 1'b0;
      drive(1'b1, 2'b00, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100));
      @(posedge clk); #1;
      drive(1'b1, 2'b01, v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0180, 16'h0180, 16'h0180));
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_ov1", 64'(b1.out_valid), 64'd1);
         check("bp_ov3", 64'(b3.out_valid), 64'd1);
         check("bp_rdy1", 64'(b1.in_ready), 64'd0);
         check("bp_rdy3", 64'(b3.in_ready), 64'd0);
         check("bp_diff1", 64'(b1.diff), 64'h0100_0100_0100);
         check("bp_diff3", 64'(b3.diff), 64'h0100_0100_0100);
         @(posedge clk); #1;
      end
      @(negedge clk);
      b1.out_ready = 1'b1;
      b3.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle1", 64'(b1.in_ready), 64'd1);
      check("bp_idle3", 64'(b3.in_ready), 64'd1);
      xact("bp2", 2'b01, v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0180, 16'h0180, 16'h0180), v3(16'hFF80, 16'hFF80, 16'hFF80), 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b00, v3(16'h7F00, 16'h7F00, 16'h7F00), v3(16'h8000, 16'h8000, 16'h8000));
      @(posedge clk); #1;
      drive(1'b0, 2'b00, '0, '0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mr_ov1", 64'(b1.out_valid), 64'd0);
      check("mr_diff1", 64'(b1.diff), 64'd0);
      check("mr_rdy1", 64'(b1.in_ready), 64'd1);
      check("mr_sat1", 64'(b1.sat), 64'd0);
      check("mr_ov3", 64'(b3.out_valid), 64'd0);
      check("mr_rdy3", 64'(b3.in_ready), 64'd1);
      @(negedge clk) rst_n = 1'b1;
      spur = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (b1.out_valid || b3.out_valid) spur++;
      end
      check("mr_spur", 64'(spur), 64'd0);
      xact("post", 2'b00, v3(16'h0180, 16'h0180, 16'h0180), v3(16'h0100, 16'h0100, 16'h0100), v3(16'h0100, 16'h0100, 16'h0100), 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
